qpsk_demap_deframe: RTL



---
 rtl/qpsk_demap_deframe.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/qpsk_demap_deframe.sv
// QPSK hard-decision demapper and 40-bit frame recovery (8-bit sync header + 32-bit payload).
// Optional macro QPSK_DEFRAME_ERRCNT_EN adds a saturating header-mismatch counter port.
module qpsk_demap_deframe #(
    parameter int         DATA_W       = 24,
    parameter int         SAMPLE_DIV   = 100,
    parameter int         SYM_SAMPLES  = 200,
    parameter int         SAMPLE_PHASE = 100,
    parameter logic [7:0] SYNC_WORD    = 8'hA5,
    parameter int         MISS_MAX     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] i_in,
    input  logic signed [DATA_W-1:0] q_in,
    output logic        [39:0]       para_out,
    output logic                     frame_valid,
    output logic                     locked,
    output logic                     sym_tick
`ifdef QPSK_DEFRAME_ERRCNT_EN
    ,
    output logic        [15:0]       sync_err_cnt
`endif
);

    localparam int SCNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int PH_W   = (SYM_SAMPLES > 1) ? $clog2(SYM_SAMPLES) : 1;
    localparam int MISS_W = $clog2(MISS_MAX + 1);

    localparam logic [SCNT_W-1:0]        SCNT_LAST = SCNT_W'(SAMPLE_DIV - 1);
    localparam logic [PH_W-1:0]          PH_LAST   = PH_W'(SYM_SAMPLES - 1);
    localparam logic [PH_W-1:0]          PH_DEC    = PH_W'(SAMPLE_PHASE);
    localparam logic [MISS_W-1:0]        MISS_LAST = MISS_W'(MISS_MAX);
    localparam logic signed [DATA_W-1:0] ZERO      = '0;

    typedef enum logic [1:0] {HUNT, COLLECT, VERIFY} state_t;

    state_t              state_q, state_d;
    logic [SCNT_W-1:0]   samp_cnt_q, samp_cnt_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic                i_bit_q, i_bit_d, q_bit_q, q_bit_d;
    logic                sh_i_q, sh_i_d, sh_q_q, sh_q_d;
    logic [39:0]         shreg_q, shreg_d;
    logic [5:0]          bit_cnt_q, bit_cnt_d;
    logic [MISS_W-1:0]   miss_q, miss_d, miss_inc;
    logic [39:0]         para_q, para_d;
    logic                fv_q, fv_d;
    logic                locked_q, locked_d;
    logic                tick, decide, shift_en, new_bit, hdr_ok, hdr_miss;
`ifdef QPSK_DEFRAME_ERRCNT_EN
    logic [15:0]         err_cnt_q, err_cnt_d;
`endif

    always_comb begin
        samp_cnt_d = samp_cnt_q + SCNT_W'(1);
        phase_d    = phase_q;
        i_bit_d    = i_bit_q;
        q_bit_d    = q_bit_q;
        shreg_d    = shreg_q;
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        miss_d     = miss_q;
        miss_inc   = miss_q + MISS_W'(1);
        para_d     = para_q;
        fv_d       = 1'b0;
        locked_d   = locked_q;
        hdr_miss   = 1'b0;

        tick   = (samp_cnt_q == SCNT_LAST);
        decide = tick && (phase_q == PH_DEC);
        if (tick) begin
            samp_cnt_d = '0;
            phase_d    = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        end
        // Non-negative samples (including exact zero) decide a 1.
        if (decide) begin
            i_bit_d = (i_in >= ZERO);
            q_bit_d = (q_in >= ZERO);
        end
        sh_i_d   = decide;
        sh_q_d   = sh_i_q;
        shift_en = sh_i_q | sh_q_q;
        new_bit  = sh_i_q ? i_bit_q : q_bit_q;
        if (shift_en) begin
            shreg_d = {shreg_q[38:0], new_bit};
        end
        hdr_ok = (shreg_d[7:0] == SYNC_WORD);

        if (shift_en) begin
            unique case (state_q)
                HUNT: begin
                    if (hdr_ok) begin
                        state_d   = COLLECT;
                        bit_cnt_d = '0;
                    end
                end
                COLLECT: begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'd31) begin
                        para_d    = shreg_d;
                        fv_d      = 1'b1;
                        locked_d  = 1'b1;
                        state_d   = VERIFY;
                        bit_cnt_d = '0;
                    end
                end
                VERIFY: begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'd7) begin
                        bit_cnt_d = '0;
                        state_d   = COLLECT;
                        if (hdr_ok) begin
                            miss_d = '0;
                        end else begin
                            hdr_miss = 1'b1;
                            // Flywheel through isolated misses; only a run of them drops lock.
                            if (miss_inc == MISS_LAST) begin
                                miss_d   = '0;
                                locked_d = 1'b0;
                                state_d  = HUNT;
                            end else begin
                                miss_d = miss_inc;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

`ifdef QPSK_DEFRAME_ERRCNT_EN
        err_cnt_d = err_cnt_q;
        if (hdr_miss && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            samp_cnt_q <= '0;
            phase_q    <= '0;
            i_bit_q    <= 1'b0;
            q_bit_q    <= 1'b0;
            sh_i_q     <= 1'b0;
            sh_q_q     <= 1'b0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            miss_q     <= '0;
            para_q     <= '0;
            fv_q       <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            phase_q    <= phase_d;
            i_bit_q    <= i_bit_d;
            q_bit_q    <= q_bit_d;
            sh_i_q     <= sh_i_d;
            sh_q_q     <= sh_q_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            miss_q     <= miss_d;
            para_q     <= para_d;
            fv_q       <= fv_d;
            locked_q   <= locked_d;
        end
    end

`ifdef QPSK_DEFRAME_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end
    assign sync_err_cnt = err_cnt_q;
`endif

    assign para_out    = para_q;
    assign frame_valid = fv_q;
    assign locked      = locked_q;
    assign sym_tick    = decide;

endmodule
